// File: rtl/matmul_operand_loader_if.sv
// Element-stream and operand-array bundle between the upstream source, the
// operand loader and the matrix multiplier.
interface matmul_operand_loader_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
);
    logic                               in_valid;
    logic                               in_ready;
    logic [WIDTH-1:0]                   in_data;
    logic                               in_last;
    logic [N-1:0][N-1:0][WIDTH-1:0]     a_out;
    logic [N-1:0][N-1:0][WIDTH-1:0]     b_out;
    logic                               mat_valid;
    logic                               result_valid;
    logic                               err;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, a_out, b_out, mat_valid, result_valid, err
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, a_out, b_out, mat_valid, result_valid, err
    );
endinterface

// File: rtl/matmul_operand_loader.sv
// Assembles a row-major A-then-B element stream into parallel operand arrays and
// holds them for the multiplier latency. Optional in_last framing check: MATMUL_LOADER_LAST_CHK_EN.
module matmul_operand_loader #(
    parameter int N       = 4,
    parameter int WIDTH   = 16,
    parameter int LATENCY = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    matmul_operand_loader_if.slave    bus
);
    localparam int NN    = N * N;
    localparam int TOTAL = 2 * NN;
    localparam int IDXW  = $clog2(TOTAL);
    localparam int CW    = $clog2(LATENCY + 1);

    typedef enum logic {
        LOAD,
        HOLD
    } state_e;

    state_e                          state_q, state_d;
    logic [IDXW-1:0]                 idx_q, idx_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [N-1:0][N-1:0][WIDTH-1:0]  a_q, a_d;
    logic [N-1:0][N-1:0][WIDTH-1:0]  b_q, b_d;
    logic                            handshake;
    logic                            lastIdx;
    logic                            badLast;

    assign handshake = bus.in_valid && bus.in_ready;
    assign lastIdx   = (idx_q == IDXW'(TOTAL - 1));

`ifdef MATMUL_LOADER_LAST_CHK_EN
    logic err_q, err_d;
    // A framing error is in_last disagreeing with the final-element position.
    assign badLast = handshake && (bus.in_last != lastIdx);
`else
    logic unusedLast;
    assign badLast    = 1'b0;
    assign unusedLast = bus.in_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef MATMUL_LOADER_LAST_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
`ifdef MATMUL_LOADER_LAST_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef MATMUL_LOADER_LAST_CHK_EN
        err_d   = badLast;
`endif
        case (state_q)
            LOAD: begin
                if (badLast) begin
                    idx_d = '0;
                end else if (handshake) begin
                    // First N*N indices fill A, the remainder fill B.
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            if (idx_q == IDXW'(r * N + c))
                                a_d[r][c] = bus.in_data;
                            if (idx_q == IDXW'(NN + r * N + c))
                                b_d[r][c] = bus.in_data;
                        end
                    end
                    if (lastIdx) begin
                        idx_d   = '0;
                        cnt_d   = CW'(LATENCY - 1);
                        state_d = HOLD;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            HOLD: begin
                if (cnt_q != '0)
                    cnt_d = cnt_q - CW'(1);
                else
                    state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        bus.in_ready     = (state_q == LOAD) && !rst;
        bus.mat_valid    = (state_q == HOLD);
        bus.result_valid = (state_q == HOLD) && (cnt_q == '0) && !rst;
`ifdef MATMUL_LOADER_LAST_CHK_EN
        bus.err          = err_q;
`else
        bus.err          = 1'b0;
`endif
    end

    assign bus.a_out = a_q;
    assign bus.b_out = b_q;
endmodule

// File: tb/tb_matmul_operand_loader.sv
// Directed bench for matmul_operand_loader: default-latency DUT plus a LATENCY=1
// DUT that sees exactly the handshakes the main DUT accepts.
module tb_matmul_operand_loader;
    logic clk;
    logic rst;
    int   vectors;
    int   errors;
    int   mv, rvAt, rvCnt, errCnt, readyCnt;
    time  rvTime, rvTimeA;
    logic [15:0] stream [32];

    matmul_operand_loader_if #(.N(4), .WIDTH(16)) bus ();
    matmul_operand_loader_if #(.N(4), .WIDTH(16)) bus1 ();

    matmul_operand_loader #(.N(4), .WIDTH(16), .LATENCY(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    matmul_operand_loader #(.N(4), .WIDTH(16), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // The short-latency copy only sees elements the main DUT accepts.
    assign bus1.in_valid = bus.in_valid & bus.in_ready;
    assign bus1.in_data  = bus.in_data;
    assign bus1.in_last  = bus.in_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Streams stream[0..31]; returns at the negedge of the first cycle after the last handshake.
    task automatic applyStimulus(input int gap);
        for (int i = 0; i < 32; i++) begin
            int guard = 0;
            while (!bus.in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) checkOutput("readyTimeout", 32'd0, 32'd1);
            bus.in_valid = 1'b1;
            bus.in_data  = stream[i];
            bus.in_last  = (i == 31);
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            if (i < 31) repeat (gap) @(negedge clk);
        end
    endtask

    // Observes cycles T0+1..T0+8, driving junk elements while the loader should be holding.
    task automatic monitorHold();
        mv = 0; rvAt = -1; rvCnt = 0; errCnt = 0; rvTime = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            bus.in_valid = (k < 6);
            bus.in_data  = 16'hDEAD;
            bus.in_last  = 1'b0;
            if (bus.mat_valid) mv++;
            if (bus.result_valid) begin
                rvCnt++;
                rvAt   = k;
                rvTime = $time;
            end
            if (bus.err) errCnt++;
            if (k == 1) checkOutput("lat1FirstCycle", {29'd0, bus1.mat_valid, bus1.result_valid, bus1.in_ready}, 32'b110);
            if (k == 2) checkOutput("lat1ReadyBack", {30'd0, bus1.in_ready, bus1.mat_valid}, 32'b10);
            if (k == 6) checkOutput("readyLowInHold", {31'd0, bus.in_ready}, 32'd0);
            if (k == 7) checkOutput("readyBack", {31'd0, bus.in_ready}, 32'd1);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rstReady", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("rstMatValid", {31'd0, bus.mat_valid}, 32'd0);
        checkOutput("rstResultValid", {31'd0, bus.result_valid}, 32'd0);
        checkOutput("rstErr", {31'd0, bus.err}, 32'd0);
        checkOutput("rstAZero", {31'd0, |bus.a_out}, 32'd0);
        checkOutput("rstBZero", {31'd0, |bus.b_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterRst", {31'd0, bus.in_ready}, 32'd1);

        // A = identity, B = 1..16, back-to-back
        for (int i = 0; i < 16; i++) begin
            stream[i]      = (i % 5 == 0) ? 16'd1 : 16'd0;
            stream[16 + i] = 16'(i + 1);
        end
        applyStimulus(0);
        checkOutput("readyLowAfterLast", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("b33", 32'(bus.b_out[3][3]), 32'd16);
        checkOutput("b12", 32'(bus.b_out[1][2]), 32'd7);
        checkOutput("a01", 32'(bus.a_out[0][1]), 32'd0);
        checkOutput("a33", 32'(bus.a_out[3][3]), 32'd1);
        monitorHold();
        checkOutput("matValidCycles", 32'(mv), 32'd6);
        checkOutput("resultValidAt", 32'(rvAt), 32'd6);
        checkOutput("resultValidCount", 32'(rvCnt), 32'd1);
        checkOutput("errQuiet", 32'(errCnt), 32'd0);
        checkOutput("a00Frozen", 32'(bus.a_out[0][0]), 32'd1);
        checkOutput("b00Frozen", 32'(bus.b_out[0][0]), 32'd1);
        checkOutput("lat1B33", 32'(bus1.b_out[3][3]), 32'd16);

        // Same stream with in_valid toggling, from a cleared array
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("clearedA", {31'd0, |bus.a_out}, 32'd0);
        applyStimulus(1);
        checkOutput("gapA22", 32'(bus.a_out[2][2]), 32'd1);
        checkOutput("gapB21", 32'(bus.b_out[2][1]), 32'd10);
        checkOutput("gapB33", 32'(bus.b_out[3][3]), 32'd16);
        monitorHold();
        checkOutput("gapResultValidAt", 32'(rvAt), 32'd6);
        checkOutput("gapMatValidCycles", 32'(mv), 32'd6);

        // Two back-to-back pairs: 2I/3I then I/5I
        for (int i = 0; i < 16; i++) begin
            stream[i]      = (i % 5 == 0) ? 16'd2 : 16'd0;
            stream[16 + i] = (i % 5 == 0) ? 16'd3 : 16'd0;
        end
        applyStimulus(0);
        checkOutput("p1A33", 32'(bus.a_out[3][3]), 32'd2);
        checkOutput("p1B00", 32'(bus.b_out[0][0]), 32'd3);
        checkOutput("p1B10", 32'(bus.b_out[1][0]), 32'd0);
        monitorHold();
        rvTimeA = rvTime;
        checkOutput("p1ResultValidAt", 32'(rvAt), 32'd6);
        for (int i = 0; i < 16; i++) begin
            stream[i]      = (i % 5 == 0) ? 16'd1 : 16'd0;
            stream[16 + i] = (i % 5 == 0) ? 16'd5 : 16'd0;
        end
        applyStimulus(0);
        monitorHold();
        checkOutput("p2ResultValidAt", 32'(rvAt), 32'd6);
        checkOutput("pairSpacing", 32'(rvTime - rvTimeA), 32'd390);
        checkOutput("p2A11", 32'(bus.a_out[1][1]), 32'd1);
        checkOutput("p2B22", 32'(bus.b_out[2][2]), 32'd5);
        checkOutput("p2B23", 32'(bus.b_out[2][3]), 32'd0);

        // Reset during HOLD cycle 3 aborts the pair
        for (int i = 0; i < 32; i++) stream[i] = 16'(16'h1000 + i);
        applyStimulus(0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("readyLowInRst", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        checkOutput("abortAZero", {31'd0, |bus.a_out}, 32'd0);
        checkOutput("abortBZero", {31'd0, |bus.b_out}, 32'd0);
        checkOutput("abortMatValid", {31'd0, bus.mat_valid}, 32'd0);
        rst = 1'b0;
        rvCnt = 0;
        readyCnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.result_valid) rvCnt++;
            if (bus.in_ready) readyCnt++;
        end
        checkOutput("abortNoResult", 32'(rvCnt), 32'd0);
        checkOutput("abortReadyCycles", 32'(readyCnt), 32'd10);

`ifdef MATMUL_LOADER_LAST_CHK_EN
        // Early in_last on element 10 is discarded and restarts the index
        for (int i = 0; i <= 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(16'h7000 + i);
            bus.in_last  = (i == 10);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checkOutput("errPulse", {31'd0, bus.err}, 32'd1);
        checkOutput("errPartialA21", 32'(bus.a_out[2][1]), 32'h7009);
        checkOutput("errDiscardA22", 32'(bus.a_out[2][2]), 32'd0);
        @(negedge clk);
        checkOutput("errSingle", {31'd0, bus.err}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            stream[i]      = (i % 5 == 0) ? 16'd1 : 16'd0;
            stream[16 + i] = 16'(i + 1);
        end
        applyStimulus(0);
        monitorHold();
        checkOutput("retryErr", 32'(errCnt), 32'd0);
        checkOutput("retryResultValidAt", 32'(rvAt), 32'd6);
        checkOutput("retryA00", 32'(bus.a_out[0][0]), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/matmul_operand_loader.md
# matmul_operand_loader

Upstream feeder for the N×N matrix multiplier. Accepts a single valid/ready element stream carrying matrix A then matrix B, row-major, and assembles them into the parallel `a_out`/`b_out` arrays. Once both matrices are complete, it holds them stable for the multiplier's fixed latency. It then pulses `result_valid` in the cycle the multiplier's `C` output is valid for those operands, and re-opens the input.

## Interface

- `N`, 4: matrix dimension; must equal the multiplier's `N`.
- `WIDTH`, 16: element bit-width; must equal the multiplier's `WIDTH`.
- `LATENCY`, 6: cycles from operands stable to multiplier `C` valid; the multiplier's `PIPE_STAGES` + 1. Legal range ≥ 1.

- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_valid`, input, 1: upstream element valid.
- `in_ready`, output, 1: loader can accept an element.
- `in_data`, input, WIDTH: element value.
- `in_last`, input, 1: marks the final element (index 2N²−1) of a pair; used only with the macro enabled.
- `a_out`, output, [N][N]×WIDTH: matrix A to the multiplier `A` port.
- `b_out`, output, [N][N]×WIDTH: matrix B to the multiplier `B` port.
- `mat_valid`, output, 1: high while A/B are complete and held.
- `result_valid`, output, 1: one-cycle pulse; downstream samples multiplier `C` in this cycle.
- `err`, output, 1: one-cycle framing-error pulse; tied 0 without the macro.

## Operation

- States: `LOAD` and `HOLD`.
- Element index `idx` runs 0..2N²−1. Wait counter `cnt` is $clog2(LATENCY+1) bits.
- **Reset:**
  - State goes to `LOAD`; `idx`=0, `cnt`=0.
  - `a_out` and `b_out` are all zeros.
  - `mat_valid`, `result_valid` and `err` are 0.
  - `in_ready` is 0 during any cycle with `rst`=1.
  - Reset mid-`LOAD` or mid-`HOLD` aborts the pair; no `result_valid` is emitted for it.
- **`LOAD`:**
  - `in_ready`=1 and `mat_valid`=0.
  - Handshake occurs when `in_valid`&&`in_ready`.
  - For `idx` < N², write `a_out[idx/N][idx%N]`; otherwise write `b_out[(idx−N²)/N][(idx−N²)%N]`. Then `idx`++.
  - Handshake at `idx`=2N²−1: write B[N−1][N−1], set `idx`←0 and `cnt`←LATENCY−1, go to `HOLD`.
  - `in_valid` low means no change; gaps of any length are legal.
- **`HOLD`:**
  - `in_ready`=0 and `mat_valid`=1.
  - `a_out` and `b_out` are frozen.
  - Each cycle, if `cnt`≠0 then `cnt`−−.
  - In the cycle `cnt`==0, `result_valid`=1 and the next state is `LOAD`.
- Unwritten positions keep their previous values; there is no clearing between pairs.
- Element routing is pure index arithmetic; no data arithmetic is performed.

## Timing

- `in_ready` is registered state decode; it has no combinational path from `in_valid`.
- Let cycle T0 be the final-element handshake. Then:
  - T0+1 is the first `HOLD` cycle, with `mat_valid`=1.
  - `result_valid`=1 in cycle T0+LATENCY.
  - `in_ready` returns to 1 in cycle T0+LATENCY+1.
- `mat_valid` is high for exactly LATENCY cycles per pair.
- Operands are stable from T0+1 through T0+LATENCY inclusive.
- Minimum period per pair is 2N²+LATENCY cycles; with defaults, 38.
- Throughput is one element per cycle in `LOAD`.
- With LATENCY=1: `HOLD` lasts one cycle and `result_valid` coincides with the first `mat_valid` cycle.

## Configuration

- Macro: `MATMUL_LOADER_LAST_CHK_EN`.
- **Defined:**
  - `in_last` is checked on every handshake.
  - `in_last`=1 at `idx`≠2N²−1: the element is discarded, `err` pulses the next cycle, `idx`←0, and the state stays `LOAD`.
  - `in_last`=0 at `idx`=2N²−1: same response; the element is discarded and `HOLD` is not entered.
  - `a_out` and `b_out` retain any partially written values.
- **Undefined:** `in_last` is ignored and `err` is constant 0.

## Test plan

- Reset, then stream A=identity and B=1..16 with `in_valid` held high: expect `in_ready` low 32 cycles after the first handshake, `b_out[3][3]`=16, `mat_valid` high for 6 cycles, and `result_valid` at T0+6. With the multiplier attached, `C` equals B.
- Same stream with `in_valid` toggling 1/0: identical array contents, and `result_valid` 6 cycles after the last handshake.
- Two back-to-back pairs (A=2·I, B=3·I, then A=I, B=5·I): two `result_valid` pulses spaced ≥38 cycles apart; sampled `C` is diag 6, then diag 5.
- Assert `rst` at `HOLD` cycle 3: no `result_valid`, arrays are zero the next cycle, and `in_ready`=1 one cycle after `rst` drops.
- LATENCY=1 build: `result_valid` and `mat_valid` are high in the same single cycle, and `in_ready` returns the next cycle.
- With `MATMUL_LOADER_LAST_CHK_EN`, drive `in_last`=1 on element 10: `err` pulses once, `idx` restarts, and a following correct 32-element pair completes with `err`=0.
